pe_mac_seq: RTL and testbench
=============================

# pe_mac_seq

Multiply-accumulate sequencer for the Eyeriss-style processing element. It sits between the ifmap/filter scratchpads (upstream) and the PE's psum output path (downstream). For each output window it consumes exactly FILT_LEN ifmap/filter pairs over valid/ready, then adds one incoming partial sum from the neighbouring PE, then presents the finished psum on a valid/ready output. The accumulator is an internal enable/clear register.

## Interface
- DATA_WIDTH, 16: width of ifmap and filter operands, signed two's complement.
- ACC_WIDTH, 32: width of the accumulator, psum_in and psum_out, signed. Must be ≥ 2*DATA_WIDTH.
- FILT_LEN, 3: products per window. Legal range is 1..(2^CNT_WIDTH − 1).
- CNT_WIDTH, 4: width of the product counter.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- start  in  1  begin a new window. Sampled only in IDLE.
- ifmap_valid  in  1 / ifmap_ready  out  1 / ifmap_data  in  DATA_WIDTH  ifmap operand stream.
- filt_valid  in  1 / filt_ready  out  1 / filt_data  in  DATA_WIDTH  filter operand stream.
- psum_in_valid  in  1 / psum_in_ready  out  1 / psum_in_data  in  ACC_WIDTH  partial sum from the neighbouring PE.
- psum_out_valid  out  1 / psum_out_ready  in  1 / psum_out_data  out  ACC_WIDTH  finished psum.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, MAC, ADD, OUT. Reset enters IDLE, clears acc and cnt.
- IDLE:
  - On start=1: go to MAC, set acc=0, cnt=0.
  - On start=0: stay in IDLE.
- MAC:
  - ifmap_ready = filt_ready = (state==MAC) && ifmap_valid && filt_valid. The two streams are always consumed as a pair, never individually.
  - On a pair handshake: acc <= acc + sext(ifmap_data*filt_data). The product is a full signed 2*DATA_WIDTH result, sign-extended to ACC_WIDTH. Then cnt <= cnt+1.
  - When the handshake that makes cnt reach FILT_LEN fires: go to ADD.
  - No handshake in a cycle: acc and cnt hold.
- ADD:
  - psum_in_ready=1.
  - On psum_in_valid: acc <= acc + psum_in_data, then go to OUT.
- OUT:
  - psum_out_valid=1 and psum_out_data=acc. The output is held stable while ready is low.
  - On psum_out_ready: go to IDLE. acc is kept until the next start clears it.
- Arithmetic: all additions wrap modulo 2^ACC_WIDTH. There is no saturation and no overflow flag.
- start outside IDLE is ignored. A window in progress is never restarted.
- All ready and valid outputs are decoded from the registered state (plus the input valids for the operand pair). There is no combinational path from psum_out_ready to any output.

## Timing
- Reset values: ifmap_ready=0, filt_ready=0, psum_in_ready=0, psum_out_valid=0, psum_out_data=0, busy=0.
- rstn assertion mid-window: outputs return to reset values immediately (asynchronously). The partial window is discarded and no psum is emitted.
- Best-case latency, with start sampled at edge 0 and all valids high:
  - Pairs are consumed at edges 1..FILT_LEN.
  - psum_in is consumed at edge FILT_LEN+1.
  - psum_out_valid is high from edge FILT_LEN+1.
  - If psum_out_ready is high, the output handshake fires at edge FILT_LEN+2, returning to IDLE.
- The next start is accepted no earlier than the first edge in IDLE. This gives one idle bubble per window.
- A valid that drops in MAC or ADD stalls the block with no state change.
- FILT_LEN=1: MAC lasts exactly one handshake.

## Test plan
- Basic window, FILT_LEN=3: ifmap 1,2,3 and filt 4,5,6, then psum_in=100 → psum_out_data=132. psum_out_valid is first high FILT_LEN+1 edges after start.
- Signed values: ifmap −2,7,−32768 and filt 3,−1,−32768, then psum_in=−5 → −6−7+1073741824−5 = 1073741806.
- Backpressure and stalls: toggle ifmap_valid and filt_valid independently, pseudo-random. The pair is consumed only when both are high, and the result still equals 132. Hold psum_out_ready=0 for 5 cycles: psum_out_data stays 132 and valid stays high.
- Wrap-around: operands 32767×32767 ×3, then psum_in=0x7FFFFFFF → result is (3*1073676289 + 2147483647) mod 2^32, interpreted as signed.
- Ignored start and back-to-back windows: pulse start during MAC → no effect. Run two windows: the second starts from acc=0, unaffected by the first result.
- Reset mid-operation: deassert rstn after 2 pairs → all outputs go to 0 and busy=0. After release plus start, a full window gives the correct result.

Source files
------------

// File: rtl/pe_mac_seq.sv
// Multiply-accumulate sequencer for one processing element: consumes FILT_LEN
// ifmap/filter pairs, adds the neighbour's partial sum, then emits the psum.
module pe_mac_seq #(
   parameter int DATA_WIDTH = 16,
   parameter int ACC_WIDTH  = 32,
   parameter int FILT_LEN   = 3,
   parameter int CNT_WIDTH  = 4
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         start,
   input  logic                         ifmap_valid,
   output logic                         ifmap_ready,
   input  logic signed [DATA_WIDTH-1:0] ifmap_data,
   input  logic                         filt_valid,
   output logic                         filt_ready,
   input  logic signed [DATA_WIDTH-1:0] filt_data,
   input  logic                         psum_in_valid,
   output logic                         psum_in_ready,
   input  logic signed [ACC_WIDTH-1:0]  psum_in_data,
   output logic                         psum_out_valid,
   input  logic                         psum_out_ready,
   output logic signed [ACC_WIDTH-1:0]  psum_out_data,
   output logic                         busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      ADD  = 2'd2,
      OUT  = 2'd3
   } state_t;

   localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(FILT_LEN - 1);

   state_t                       state;
   logic signed [ACC_WIDTH-1:0]  acc;
   logic [CNT_WIDTH-1:0]         cnt;
   logic                         pair_fire;

   // Full-precision signed product, sign-extended, added with modular wrap.
   function automatic logic signed [ACC_WIDTH-1:0] mac_step(
      input logic signed [ACC_WIDTH-1:0]  a,
      input logic signed [DATA_WIDTH-1:0] x,
      input logic signed [DATA_WIDTH-1:0] w
   );
      logic signed [2*DATA_WIDTH-1:0] prod;
      prod = x * w;
      return a + ACC_WIDTH'(prod);
   endfunction

   function automatic logic signed [ACC_WIDTH-1:0] wrap_add(
      input logic signed [ACC_WIDTH-1:0] a,
      input logic signed [ACC_WIDTH-1:0] b
   );
      return a + b;
   endfunction

   assign pair_fire = (state == MAC) && ifmap_valid && filt_valid;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
         acc   <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state <= MAC;
                  acc   <= '0;
                  cnt   <= '0;
               end
            end
            MAC: begin
               if (pair_fire) begin
                  acc <= mac_step(acc, ifmap_data, filt_data);
                  cnt <= cnt + 1'b1;
                  if (cnt == LAST_CNT) state <= ADD;
               end
            end
            ADD: begin
               if (psum_in_valid) begin
                  acc   <= wrap_add(acc, psum_in_data);
                  state <= OUT;
               end
            end
            OUT: begin
               // acc is left intact; the next start clears it.
               if (psum_out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign ifmap_ready    = pair_fire;
   assign filt_ready     = pair_fire;
   assign psum_in_ready  = (state == ADD);
   assign psum_out_valid = (state == OUT);
   assign psum_out_data  = acc;
   assign busy           = (state != IDLE);

endmodule

// File: tb/tb_pe_mac_seq.sv
// Bench for pe_mac_seq: fixed vector table, randomized stalls and operands
// against an arithmetic model, plus reset and ignored-start sequences.
module tb_pe_mac_seq;

   localparam int FL = 3;

   logic               clk = 1'b0;
   logic               rstn = 1'b0;
   logic               start = 1'b0;
   logic               ifmap_valid = 1'b0;
   logic               ifmap_ready;
   logic signed [15:0] ifmap_data = '0;
   logic               filt_valid = 1'b0;
   logic               filt_ready;
   logic signed [15:0] filt_data = '0;
   logic               psum_in_valid = 1'b0;
   logic               psum_in_ready;
   logic signed [31:0] psum_in_data = '0;
   logic               psum_out_valid;
   logic               psum_out_ready = 1'b0;
   logic signed [31:0] psum_out_data;
   logic               busy;

   int n_cmp = 0;
   int n_bad = 0;
   int edge_cnt = 0;

   pe_mac_seq #(
      .DATA_WIDTH(16), .ACC_WIDTH(32), .FILT_LEN(FL), .CNT_WIDTH(4)
   ) dut (
      .clk(clk), .rstn(rstn), .start(start),
      .ifmap_valid(ifmap_valid), .ifmap_ready(ifmap_ready), .ifmap_data(ifmap_data),
      .filt_valid(filt_valid), .filt_ready(filt_ready), .filt_data(filt_data),
      .psum_in_valid(psum_in_valid), .psum_in_ready(psum_in_ready), .psum_in_data(psum_in_data),
      .psum_out_valid(psum_out_valid), .psum_out_ready(psum_out_ready),
      .psum_out_data(psum_out_data), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   typedef struct packed {
      logic [FL-1:0][15:0] ifm;
      logic [FL-1:0][15:0] flt;
      logic [31:0]         psum;
      logic [31:0]         exp;
   } vec_t;

   vec_t tbl[4];

   task automatic check(input string name, input logic signed [63:0] act,
                        input logic signed [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference: sum of exact products plus psum, reduced modulo 2^32.
   function automatic logic signed [31:0] model(input vec_t v);
      longint s;
      logic [63:0] s_bits;
      s = 0;
      for (int k = 0; k < FL; k++)
         s += longint'($signed(v.ifm[k])) * longint'($signed(v.flt[k]));
      s += longint'($signed(v.psum));
      s_bits = s;
      return $signed(s_bits[31:0]);
   endfunction

   task automatic check_idle_outputs(input string tag);
      check({tag, "_ifmap_ready"}, 64'(ifmap_ready), 0);
      check({tag, "_filt_ready"}, 64'(filt_ready), 0);
      check({tag, "_psum_in_ready"}, 64'(psum_in_ready), 0);
      check({tag, "_psum_out_valid"}, 64'(psum_out_valid), 0);
      check({tag, "_psum_out_data"}, 64'(psum_out_data), 0);
      check({tag, "_busy"}, 64'(busy), 0);
   endtask

   // Runs one window starting at a negedge; ends at a negedge back in IDLE.
   task automatic run_window(input vec_t v, input bit stall, input bit poke_start,
                             input int hold, output logic signed [31:0] res);
      int k, cyc, t0;
      bit fire, iv, fv;
      res = '0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      t0 = edge_cnt;
      check("busy_after_start", 64'(busy), 1);
      k = 0;
      cyc = 0;
      while (k < FL && cyc < 200) begin
         iv = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         fv = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         ifmap_valid = iv;
         filt_valid  = fv;
         ifmap_data  = $signed(v.ifm[k]);
         filt_data   = $signed(v.flt[k]);
         start       = poke_start && (cyc % 2 == 0);
         #1;
         fire = ifmap_ready;
         if (stall) begin
            check("pair_ready", 64'(ifmap_ready), 64'(iv && fv));
            check("ready_match", 64'(filt_ready), 64'(ifmap_ready));
         end
         @(negedge clk);
         if (fire) k++;
         cyc++;
      end
      ifmap_valid = 1'b0;
      filt_valid  = 1'b0;
      start       = 1'b0;
      if (k < FL) begin
         check("timeout_mac", 0, 1);
         return;
      end
      cyc = 0;
      fire = 1'b0;
      psum_in_data = $signed(v.psum);
      while (!fire && cyc < 200) begin
         psum_in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         fire = psum_in_ready && psum_in_valid;
         if (cyc == 0) check("psum_in_ready", 64'(psum_in_ready), 1);
         @(negedge clk);
         cyc++;
      end
      psum_in_valid = 1'b0;
      if (!fire) begin
         check("timeout_add", 0, 1);
         return;
      end
      check("out_valid", 64'(psum_out_valid), 1);
      if (!stall) check("latency", 64'(edge_cnt - t0), FL + 1);
      res = psum_out_data;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check("hold_valid", 64'(psum_out_valid), 1);
         check("hold_data", 64'(psum_out_data), 64'(res));
      end
      psum_out_ready = 1'b1;
      @(negedge clk);
      psum_out_ready = 1'b0;
      check("out_done_valid", 64'(psum_out_valid), 0);
      check("out_done_busy", 64'(busy), 0);
   endtask

   initial begin
      logic signed [31:0] res;
      vec_t rv;

      tbl[0] = '{ifm: {16'sd3, 16'sd2, 16'sd1}, flt: {16'sd6, 16'sd5, 16'sd4},
                 psum: 32'sd100, exp: 32'sd132};
      tbl[1] = '{ifm: {-16'sd32768, 16'sd7, -16'sd2}, flt: {-16'sd32768, -16'sd1, 16'sd3},
                 psum: -32'sd5, exp: 32'sd1073741806};
      tbl[2] = '{ifm: {16'sd32767, 16'sd32767, 16'sd32767}, flt: {16'sd32767, 16'sd32767, 16'sd32767},
                 psum: 32'h7FFF_FFFF, exp: 32'sd1073545218};
      tbl[3] = '{ifm: {-16'sd1, 16'sd0, 16'sd5}, flt: {16'sd9, 16'sd4, -16'sd8},
                 psum: -32'sd1, exp: -32'sd50};

      // Reset state with inputs asserted
      ifmap_valid = 1'b1;
      filt_valid  = 1'b1;
      psum_in_valid = 1'b1;
      psum_out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      ifmap_valid = 1'b0;
      filt_valid  = 1'b0;
      psum_in_valid = 1'b0;
      psum_out_ready = 1'b0;
      rstn = 1'b1;
      @(negedge clk);
      check("idle_no_start", 64'(busy), 0);

      for (int i = 0; i < 4; i++) begin
         run_window(tbl[i], 1'b0, 1'b0, (i == 0) ? 5 : 0, res);
         check($sformatf("table_%0d", i), 64'(res), 64'($signed(tbl[i].exp)));
      end

      // Stalled valids, start poked during MAC, long output backpressure
      run_window(tbl[0], 1'b1, 1'b1, 5, res);
      check("stall_result", 64'(res), 132);

      // Back-to-back: second window must not inherit the first result
      run_window(tbl[1], 1'b0, 1'b0, 0, res);
      check("b2b_first", 64'(res), 1073741806);
      run_window(tbl[3], 1'b0, 1'b0, 0, res);
      check("b2b_second", 64'(res), -50);

      // Asynchronous reset after two pairs
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ifmap_valid = 1'b1;
      filt_valid  = 1'b1;
      ifmap_data  = 16'sd3;
      filt_data   = 16'sd7;
      repeat (2) @(negedge clk);
      #2;
      rstn = 1'b0;
      #1;
      check_idle_outputs("midreset");
      @(negedge clk);
      ifmap_valid = 1'b0;
      filt_valid  = 1'b0;
      rstn = 1'b1;
      @(negedge clk);
      check("post_reset_valid", 64'(psum_out_valid), 0);
      run_window(tbl[0], 1'b0, 1'b0, 0, res);
      check("post_reset_result", 64'(res), 132);

      // Random operands and stalls against the arithmetic model
      for (int n = 0; n < 20; n++) begin
         for (int k = 0; k < FL; k++) begin
            rv.ifm[k] = 16'($urandom);
            rv.flt[k] = 16'($urandom);
         end
         rv.psum = $urandom;
         rv.exp  = '0;
         run_window(rv, 1'b1, 1'(n % 3 == 0), n % 4, res);
         check($sformatf("rand_%0d", n), 64'(res), 64'(model(rv)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, got running expected done");
      $fatal(1, "timeout");
   end

endmodule
